// File: rtl/fft_16pt.sv
// fft_16pt: streaming 16-point running DFT with per-bin L1 magnitude output
//
// Ports:
//   clk             rising-edge system clock
//   rst_n           asynchronous active-low reset
//   audio_in        signed 16-bit sample, one consumed every clock
//   fft_output_0..15 registered unsigned magnitude of bins 0..15
//   frame_valid     one-cycle pulse in the cycle the outputs are updated
//
// Sixteen complex accumulators share one twiddle ROM. Each bin k uses the
// entry m = (k*n) mod 16, where n is the sample index within the frame.
module fft_16pt #(
    parameter int SCALE_SHIFT = 4,
    parameter int TW_FRAC     = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] audio_in,
    output logic [15:0] fft_output_0,
    output logic [15:0] fft_output_1,
    output logic [15:0] fft_output_2,
    output logic [15:0] fft_output_3,
    output logic [15:0] fft_output_4,
    output logic [15:0] fft_output_5,
    output logic [15:0] fft_output_6,
    output logic [15:0] fft_output_7,
    output logic [15:0] fft_output_8,
    output logic [15:0] fft_output_9,
    output logic [15:0] fft_output_10,
    output logic [15:0] fft_output_11,
    output logic [15:0] fft_output_12,
    output logic [15:0] fft_output_13,
    output logic [15:0] fft_output_14,
    output logic [15:0] fft_output_15,
    output logic        frame_valid
);
    // 40 bits holds 16 * 2^15 * 2^14 with ample margin, and the sum of two
    // magnitudes, so neither accumulation nor |Re|+|Im| can overflow.
    localparam int AW = 40;

    logic        [3:0]    n_q, n_d;
    logic                 fv_q, fv_d;
    logic signed [AW-1:0] re_q [16];
    logic signed [AW-1:0] re_d [16];
    logic signed [AW-1:0] im_q [16];
    logic signed [AW-1:0] im_d [16];
    logic        [15:0]   mag_q [16];
    logic        [15:0]   mag_d [16];
    logic        [3:0]    m_k [16];
    logic signed [31:0]   p_re [16];
    logic signed [31:0]   p_im [16];
    logic        [AW-1:0] sum_k [16];
    logic        [AW-1:0] sh_k [16];

    // Q1.14 cosine table; sine is the same table delayed by a quarter turn.
    function automatic logic signed [15:0] cos_tw(input logic [3:0] m);
        case (m)
            4'd0:    cos_tw = 16'sd16384;
            4'd1:    cos_tw = 16'sd15137;
            4'd2:    cos_tw = 16'sd11585;
            4'd3:    cos_tw = 16'sd6270;
            4'd4:    cos_tw = 16'sd0;
            4'd5:    cos_tw = -16'sd6270;
            4'd6:    cos_tw = -16'sd11585;
            4'd7:    cos_tw = -16'sd15137;
            4'd8:    cos_tw = -16'sd16384;
            4'd9:    cos_tw = -16'sd15137;
            4'd10:   cos_tw = -16'sd11585;
            4'd11:   cos_tw = -16'sd6270;
            4'd12:   cos_tw = 16'sd0;
            4'd13:   cos_tw = 16'sd6270;
            4'd14:   cos_tw = 16'sd11585;
            default: cos_tw = 16'sd15137;
        endcase
    endfunction

    // Absolute value in the full accumulator width so the most negative
    // frame sum cannot wrap.
    function automatic logic [AW-1:0] abs_f(input logic signed [AW-1:0] v);
        return v[AW-1] ? AW'(-v) : AW'(v);
    endfunction

    always_comb begin
        n_d  = n_q + 4'd1;
        fv_d = (n_q == 4'd15);
        for (int k = 0; k < 16; k++) begin
            m_k[k]   = 4'(k) * n_q;
            p_re[k]  = $signed(audio_in) * cos_tw(m_k[k]);
            p_im[k]  = $signed(audio_in) * cos_tw(m_k[k] - 4'd4);
            // n = 0 starts a new frame: load the product, drop the old sum.
            re_d[k]  = (n_q == 4'd0 ? '0 : re_q[k]) + AW'(p_re[k]);
            im_d[k]  = (n_q == 4'd0 ? '0 : im_q[k]) - AW'(p_im[k]);
            sum_k[k] = abs_f(re_d[k]) + abs_f(im_d[k]);
            sh_k[k]  = sum_k[k] >> (TW_FRAC + SCALE_SHIFT);
            mag_d[k] = !fv_d ? mag_q[k] :
                       (|sh_k[k][AW-1:16]) ? 16'hFFFF : sh_k[k][15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q  <= '0;
            fv_q <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                re_q[k]  <= '0;
                im_q[k]  <= '0;
                mag_q[k] <= '0;
            end
        end else begin
            n_q  <= n_d;
            fv_q <= fv_d;
            for (int k = 0; k < 16; k++) begin
                re_q[k]  <= re_d[k];
                im_q[k]  <= im_d[k];
                mag_q[k] <= mag_d[k];
            end
        end
    end

    assign frame_valid   = fv_q;
    assign fft_output_0  = mag_q[0];
    assign fft_output_1  = mag_q[1];
    assign fft_output_2  = mag_q[2];
    assign fft_output_3  = mag_q[3];
    assign fft_output_4  = mag_q[4];
    assign fft_output_5  = mag_q[5];
    assign fft_output_6  = mag_q[6];
    assign fft_output_7  = mag_q[7];
    assign fft_output_8  = mag_q[8];
    assign fft_output_9  = mag_q[9];
    assign fft_output_10 = mag_q[10];
    assign fft_output_11 = mag_q[11];
    assign fft_output_12 = mag_q[12];
    assign fft_output_13 = mag_q[13];
    assign fft_output_14 = mag_q[14];
    assign fft_output_15 = mag_q[15];
endmodule

// File: tb/tb_fft_16pt.sv
// tb_fft_16pt: directed self-checking bench for fft_16pt with a DFT reference model
module tb_fft_16pt;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] audio_in = '0;
    logic [15:0] o [16];
    logic        frame_valid;

    int total = 0;
    int bad = 0;
    int cnt = 0;
    int smp [16];
    logic [255:0] cur = '0;
    logic [255:0] exp_q [$];
    int ctab [16] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137,
                      -16384, -15137, -11585, -6270, 0, 6270, 11585, 15137};

    fft_16pt dut (
        .clk(clk), .rst_n(rst_n), .audio_in(audio_in),
        .fft_output_0(o[0]), .fft_output_1(o[1]), .fft_output_2(o[2]),
        .fft_output_3(o[3]), .fft_output_4(o[4]), .fft_output_5(o[5]),
        .fft_output_6(o[6]), .fft_output_7(o[7]), .fft_output_8(o[8]),
        .fft_output_9(o[9]), .fft_output_10(o[10]), .fft_output_11(o[11]),
        .fft_output_12(o[12]), .fft_output_13(o[13]), .fft_output_14(o[14]),
        .fft_output_15(o[15]), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bins(input string tag);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s_bin%0d", tag, k), 32'(o[k]), 32'(cur[k*16 +: 16]));
    endtask

    // Reference DFT of the buffered frame, using the twiddle values as listed.
    task automatic model_push();
        logic [255:0] e;
        e = '0;
        for (int k = 0; k < 16; k++) begin
            longint re = 0, im = 0, s;
            for (int n = 0; n < 16; n++) begin
                re += longint'(smp[n]) * ctab[(k * n) % 16];
                im -= longint'(smp[n]) * ctab[((k * n) + 12) % 16];
            end
            s = ((re < 0 ? -re : re) + (im < 0 ? -im : im)) >>> 18;
            e[k*16 +: 16] = s > 65535 ? 16'hFFFF : 16'(s);
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input int x);
        logic fv_exp;
        audio_in = 16'(x);
        smp[cnt] = x;
        fv_exp = (cnt == 15);
        if (fv_exp) model_push();
        @(posedge clk);
        #1;
        cnt = (cnt + 1) % 16;
        check("frame_valid", 32'(frame_valid), 32'(fv_exp));
        if (fv_exp) begin
            check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
        end
        check_bins("out");
    endtask

    task automatic frame_const(input int x);
        for (int i = 0; i < 16; i++) step(x);
    endtask

    initial begin
        audio_in = 16'd500;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fv", 32'(frame_valid), 32'd0);
        check_bins("rst");
        rst_n = 1'b1;

        frame_const(100);
        check("dc_pos_bin0", 32'(o[0]), 32'd100);
        check("dc_pos_bin1", 32'(o[1]), 32'd0);
        check("dc_pos_bin15", 32'(o[15]), 32'd0);

        frame_const(-100);
        check("dc_neg_bin0", 32'(o[0]), 32'd100);

        step(1600);
        for (int i = 0; i < 15; i++) step(0);
        check("imp0_bin0", 32'(o[0]), 32'd100);
        check("imp0_bin1", 32'(o[1]), 32'd100);
        check("imp0_bin4", 32'(o[4]), 32'd100);

        step(0);
        step(1600);
        for (int i = 0; i < 14; i++) step(0);
        check("imp1_bin0", 32'(o[0]), 32'd100);
        check("imp1_bin1", 32'(o[1]), 32'd130);
        check("imp1_bin2", 32'(o[2]), 32'd141);
        check("imp1_bin4", 32'(o[4]), 32'd100);
        check("imp1_bin8", 32'(o[8]), 32'd100);

        for (int i = 0; i < 16; i++) step(i % 2 == 0 ? 100 : -100);
        check("nyq_bin8", 32'(o[8]), 32'd100);
        check("nyq_bin0", 32'(o[0]), 32'd0);
        check("nyq_bin7", 32'(o[7]), 32'd0);

        frame_const(32767);
        check("sat_pos_bin0", 32'(o[0]), 32'd32767);
        frame_const(-32768);
        check("sat_neg_bin0", 32'(o[0]), 32'd32768);

        frame_const(100);
        for (int i = 0; i < 7; i++) step(100);
        rst_n = 1'b0;
        #3;
        cur = '0;
        cnt = 0;
        exp_q.delete();
        check("midrst_async_fv", 32'(frame_valid), 32'd0);
        check_bins("midrst_async");
        @(posedge clk);
        #1;
        check_bins("midrst_hold");
        rst_n = 1'b1;
        frame_const(100);
        check("post_rst_bin0", 32'(o[0]), 32'd100);

        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 16; i++) step($signed(16'($urandom)));
        frame_const(100);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
